stream_framer: RTL and testbench
================================

Name: stream_framer

Overview:
- Sits between data_generator and data_gateway on the tx path, in the 80 MHz domain.
- Accepts the raw 32-bit word stream with valid/ready flow control.
- Wraps the stream into fixed-length frames: header word, PAYLOAD_LEN payload words, optional checksum trailer.
- Frames are pushed into data_gateway via tx_valid/tx_data/tx_ready, so the host can detect dropped or reordered frames.

Parameters:
- PAYLOAD_LEN, 256: payload words per frame. Legal range 1..65535.
- MAGIC, 16'hA55A: constant placed in header bits [31:16].
- SEQ_W, 16: sequence counter width. Header carries the low 16 bits.

Ports:
- clk_in  input  1  80 MHz stream clock.
- rst_in  input  1  asynchronous, active-high reset.
- enable  input  1  permits start of a new frame; sampled only in IDLE.
- in_valid  input  1  upstream word valid.
- in_data  input  32  upstream word.
- in_ready  output  1  upstream word accepted when in_valid && in_ready.
- out_valid  output  1  framed word valid (to data_gateway tx_valid).
- out_data  output  32  framed word (to tx_data).
- out_ready  input  1  downstream accept (from tx_ready).
- busy  output  1  high from HEADER entry until last word of frame accepted downstream.
- frame_done  output  1  one-cycle pulse when last word of a frame is accepted downstream.
- seq_out  output  SEQ_W  sequence number of the next frame to be started.

Behaviour:
- Reset: all outputs 0, state IDLE, sequence counter 0, payload counter 0, checksum 0. Any partial frame is discarded; no trailer is emitted.
- Output register: out_valid/out_data are registered. The register loads when (!out_valid || out_ready). out_data holds stable while out_valid && !out_ready.
- in_ready = (state==PAYLOAD) && (!out_valid || out_ready). Purely combinational from state and out_valid/out_ready; never depends on in_valid.
- Latency: an accepted input word appears on out_data the next cycle.
- IDLE -> HEADER when enable && in_valid && output register free.
  - Load out_data = {MAGIC, seq[15:0]}.
  - Clear checksum and payload counter.
  - No input word is consumed in this cycle.
- HEADER -> PAYLOAD in the same cycle the header is loaded. The state is only observable for one cycle.
- PAYLOAD: each accepted word is copied to out_data, added to checksum (32-bit sum, modulo 2^32) and increments the payload counter.
  - On acceptance of word number PAYLOAD_LEN, go to TRAILER, or to DONE_WAIT if the trailer is compiled out.
- TRAILER: when the output register is free, load out_data = checksum, then go to DONE_WAIT.
- DONE_WAIT: when the last loaded word is accepted downstream (out_valid && out_ready):
  - pulse frame_done;
  - increment seq (wraps 16'hFFFF -> 0);
  - go to IDLE.
- The next frame's header may be loaded in the same cycle the previous last word is accepted, giving back-to-back frames with zero bubble.
- enable deassertion mid-frame does not abort; the current frame completes. enable only gates IDLE exit.
- Input stall (in_valid low in PAYLOAD): out_valid drops after the register drains. No filler words are inserted.
- Simultaneous last-payload accept and out_ready: handled by the register rule above. No word is lost or duplicated.
- PAYLOAD_LEN==1: the frame is header, one word, then trailer.

Optional Feature:
- Macro: STREAM_FRAMER_TRAILER_EN.
- Defined: the TRAILER state exists. Frame length is PAYLOAD_LEN+2 words, with the last word being the 32-bit sum of the payload.
- Undefined: the checksum logic and TRAILER state are removed. Frame length is PAYLOAD_LEN+1 words; PAYLOAD goes straight to DONE_WAIT.

Decomposition:
- Package stream_pkg holds:
  - state encoding constants (IDLE, HEADER, PAYLOAD, TRAILER, DONE_WAIT);
  - default MAGIC 16'hA55A;
  - header field bit positions.
- One natural sub-module, stream_skid_reg: the output register with the valid/ready load rule, reusable on other tx paths.

Test Plan:
- PAYLOAD_LEN=4, enable=1, in words 1,2,3,4 continuous, out_ready=1 -> out sequence A55A0000, 1, 2, 3, 4, 0000000A; frame_done pulses once; seq_out becomes 1.
- Same config, out_ready toggling 1/0 every cycle -> identical word sequence, no duplicates; out_data stable while stalled.
- Run 65537 frames with PAYLOAD_LEN=1 -> header of frame 65536 is A55A0000 (wrap); seq_out=1 after the last frame.
- Drop enable after the 2nd payload word of a 4-word frame -> frame completes with trailer; no new header while enable=0.
- Assert rst_in mid-payload after word 2 -> outputs 0 immediately; after release the first word out is A55A0000.
- Build without STREAM_FRAMER_TRAILER_EN, PAYLOAD_LEN=4 -> 5-word frames; frame_done on word 4; no checksum word.

Source files
------------

// File: rtl/stream_pkg.sv
// stream_pkg: framer state encoding, header layout and default magic.
package stream_pkg;
  typedef enum logic [2:0] {IDLE, HEADER, PAYLOAD, TRAILER, DONE_WAIT} state_e;
  localparam logic [15:0] MAGIC_DEF = 16'hA55A;
  localparam int HDR_MAGIC_LSB = 16;
  localparam int HDR_SEQ_LSB = 0;
  function automatic logic [31:0] make_hdr(input logic [15:0] magic, input logic [15:0] seq);
    return (32'(magic) << HDR_MAGIC_LSB) | (32'(seq) << HDR_SEQ_LSB);
  endfunction
endpackage

// File: rtl/stream_skid_reg.sv
// stream_skid_reg: single output register that loads whenever empty or being drained.
module stream_skid_reg #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         ld_valid_i,
  input  logic [W-1:0] ld_data_i,
  input  logic         ready_i,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  output logic         free_o
);
  logic         valid_q;
  logic [W-1:0] data_q;
  assign free_o  = !valid_q || ready_i;
  assign valid_o = valid_q;
  assign data_o  = data_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (free_o) begin
      valid_q <= ld_valid_i;
      if (ld_valid_i) data_q <= ld_data_i;
    end
  end
endmodule

// File: rtl/stream_framer.sv
// stream_framer: wraps a 32-bit word stream into header + payload frames with a sequence number.
// Define STREAM_FRAMER_TRAILER_EN to append a 32-bit payload sum as the last word of each frame.
module stream_framer
  import stream_pkg::*;
#(
  parameter int          PAYLOAD_LEN = 256,
  parameter logic [15:0] MAGIC       = MAGIC_DEF,
  parameter int          SEQ_W       = 16
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             enable,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [31:0]      out_data,
  input  logic             out_ready,
  output logic             busy,
  output logic             frame_done,
  output logic [SEQ_W-1:0] seq_out
);
  state_e           state_q;
  logic [15:0]      cnt_q;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic             done_q, free, acc, fin, start, ld_v;
  logic [31:0]      ld_d;
`ifdef STREAM_FRAMER_TRAILER_EN
  logic [31:0]      csum_q;
`endif
  stream_skid_reg #(.W(32)) u_out (
    .clk_i(clk_in), .rst_i(rst_in), .ld_valid_i(ld_v), .ld_data_i(ld_d),
    .ready_i(out_ready), .valid_o(out_valid), .data_o(out_data), .free_o(free)
  );
  assign in_ready   = (state_q == PAYLOAD) && free;
  assign busy       = state_q != IDLE;
  assign frame_done = done_q;
  assign seq_out    = seq_q;
  // a back-to-back header carries the sequence number of the frame that follows the one finishing
  always_comb begin
    seq_d = seq_q + SEQ_W'(state_q == DONE_WAIT);
    fin   = (state_q == DONE_WAIT) && out_valid && out_ready;
    start = enable && in_valid && (fin || (state_q == IDLE && free));
    acc   = in_valid && in_ready;
`ifdef STREAM_FRAMER_TRAILER_EN
    ld_v  = start || acc || (state_q == TRAILER && free);
    ld_d  = start ? make_hdr(MAGIC, 16'(seq_d)) : acc ? in_data : csum_q;
`else
    ld_v  = start || acc;
    ld_d  = start ? make_hdr(MAGIC, 16'(seq_d)) : in_data;
`endif
  end
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      seq_q   <= '0;
      done_q  <= 1'b0;
`ifdef STREAM_FRAMER_TRAILER_EN
      csum_q  <= '0;
`endif
    end else begin
      done_q <= fin;
      if (fin) seq_q <= seq_d;
      case (state_q)
        IDLE, DONE_WAIT: begin
          if (start) begin
            state_q <= HEADER;
            cnt_q   <= '0;
`ifdef STREAM_FRAMER_TRAILER_EN
            csum_q  <= '0;
`endif
          end else if (fin) state_q <= IDLE;
        end
        HEADER: state_q <= PAYLOAD;
        PAYLOAD: begin
          if (acc) begin
            cnt_q <= cnt_q + 16'd1;
`ifdef STREAM_FRAMER_TRAILER_EN
            csum_q <= csum_q + in_data;
            if (cnt_q == 16'(PAYLOAD_LEN - 1)) state_q <= TRAILER;
`else
            if (cnt_q == 16'(PAYLOAD_LEN - 1)) state_q <= DONE_WAIT;
`endif
          end
        end
`ifdef STREAM_FRAMER_TRAILER_EN
        TRAILER: if (free) state_q <= DONE_WAIT;
`endif
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_stream_framer.sv
// tb_stream_framer: randomized scoreboard bench for stream_framer (PAYLOAD_LEN=4, SEQ_W=4).
module tb_stream_framer;
  localparam int LEN = 4;
  localparam int SW  = 4;
`ifdef STREAM_FRAMER_TRAILER_EN
  localparam int FW = LEN + 2;
`else
  localparam int FW = LEN + 1;
`endif
  logic          clk = 1'b0, rst_in = 1'b1, enable = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0]   in_data = '0;
  logic          in_ready, out_valid, busy, frame_done;
  logic [31:0]   out_data;
  logic [SW-1:0] seq_out;
  int            checks = 0, errors = 0;
  logic [31:0]   sbq[$];
  bit            mon_en = 1'b0;
  always #5 clk = ~clk;
  stream_framer #(.PAYLOAD_LEN(LEN), .SEQ_W(SW)) dut (
    .clk_in(clk), .rst_in(rst_in), .enable(enable), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .frame_done(frame_done), .seq_out(seq_out)
  );
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", n, a, e, $time);
    end
  endtask
  int          pos, nf;
  bit          dn, pv, pr, pen;
  logic [31:0] pd, e;
  always @(negedge clk) begin
    if (!mon_en) begin
      pos = 0; nf = 0; dn = 0; pv = 0; pr = 0; pen = 0; pd = '0;
    end else begin
      chk("frame_done", 32'(frame_done), 32'(dn));
      chk("seq_out", 32'(seq_out), 32'(nf % (1 << SW)));
      if (pv && !pr) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_data", out_data, pd);
      end
      if (out_valid && (!pv || pr) && pos == 0) chk("hdr_needs_enable", 32'(pen), 32'd1);
      dn = 0;
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) chk("unexpected_word", out_data, 32'hxxxxxxxx);
        else begin
          e = sbq.pop_front();
          chk("word", out_data, e);
        end
        pos++;
        if (pos == FW) begin
          pos = 0; dn = 1; nf++;
        end
      end
      pv = out_valid; pr = out_ready; pd = out_data; pen = enable;
    end
  end
  int          nw, a;
  bit          have, took, seen;
  logic [31:0] cur, sum, v;
  initial begin
    nw = 0; have = 0; took = 0; sum = '0; cur = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_seq_out", 32'(seq_out), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    rst_in = 1'b0;
    mon_en = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      took = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (took) have = 0;
      if (!have && (c < 3000 || nw % LEN != 0)) begin
        if (nw % LEN == 0) begin
          sbq.push_back({16'hA55A, 16'((nw / LEN) % (1 << SW))});
          sum = '0;
        end
        cur = $urandom;
        sbq.push_back(cur);
        sum += cur;
        nw++;
`ifdef STREAM_FRAMER_TRAILER_EN
        if (nw % LEN == 0) sbq.push_back(sum);
`endif
        have = 1;
      end
      in_valid  = have && (c >= 3000 || $urandom_range(3, 0) != 0);
      in_data   = cur;
      out_ready = c >= 3000 || $urandom_range(2, 0) != 0;
      enable    = c >= 3000 || $urandom_range(7, 0) != 0;
    end
    in_valid = 1'b0;
    for (int c = 0; c < 200 && (sbq.size() != 0 || busy); c++) @(posedge clk);
    #1;
    chk("drain_queue", 32'(sbq.size()), 32'd0);
    chk("drain_busy", 32'(busy), 32'd0);
    chk("frames_seen", 32'(nf), 32'(nw / LEN));
    mon_en = 1'b0;
    a = 0;
    in_data = 32'd1; in_valid = 1'b1; enable = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 50 && a < 2; c++) begin
      @(negedge clk);
      if (in_valid && in_ready) a++;
      @(posedge clk);
      #1;
      in_data = in_data + 32'd1;
    end
    chk("midframe_reached", 32'(a), 32'd2);
    rst_in = 1'b1;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_data", out_data, 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_seq", 32'(seq_out), 32'd0);
    chk("async_rst_in_ready", 32'(in_ready), 32'd0);
    sbq.delete();
    @(posedge clk);
    #1;
    rst_in = 1'b0;
    seen = 0; v = '0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1; v = out_data;
      end
    end
    chk("post_rst_seen", 32'(seen), 32'd1);
    chk("post_rst_hdr", v, 32'hA55A0000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
